pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is clk, and the reset rst_n is asynchronous and active-low.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  execute stage held; no resolution this cycle
- br_valid  in  1  conditional branch present in execute stage
- jump  in  1  JAL/JALR present in execute stage
- funct3  in  3  branch funct3 of execute-stage instruction
- BrEQ  in  1  equal result from branch comparator
- BrLT  in  1  less-than result from branch comparator
- target  in  32  computed branch/jump target
- BrUn  out  1  comparator unsigned select
- pc  out  32  fetch program counter
- flush  out  1  squash the fetch and decode instructions
- taken  out  1  registered: last resolution redirected the PC
- misalign  out  1  one-cycle pulse: target[1] set on a redirect
- illegal_br  out  1  one-cycle pulse: funct3 is 010 or 011 with br_valid set
- br_cnt  out  32  resolved branch/jump count
- taken_cnt  out  32  redirect count

Function
REQ-003 BrUn SHALL be combinational and equal funct3[2] & funct3[1].
REQ-004 Decision SHALL be combinational from funct3:
- 000: BrEQ
- 001: !BrEQ
- 100 and 110: BrLT
- 101 and 111: !BrLT
- 010 and 011: not taken, and illegal_br pulses
REQ-005 jump SHALL force the decision to taken; if jump and br_valid are both set, jump wins.
REQ-006 The FSM SHALL have states RUN and FLUSH, with a 1-bit flush counter.
REQ-007 In RUN with stall=0, a taken decision SHALL take effect at the next edge:
- pc <= {target[31:1],1'b0}
- taken <= 1
- state <= FLUSH
- counter <= 1
REQ-008 In RUN with stall=0 and no taken decision, the next edge SHALL give pc <= pc+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000) and taken <= 0.
REQ-009 In RUN with stall=1, pc, taken and the state SHALL hold, and br_valid/jump SHALL be ignored.
REQ-010 flush SHALL be registered and equal 1 exactly while state==FLUSH, which lasts two cycles.
REQ-011 In FLUSH, the counter SHALL decrement every cycle regardless of stall, and the FSM returns to RUN after the counter==0 cycle.
REQ-012 In FLUSH, br_valid and jump SHALL be ignored, and pc SHALL advance by 4 when stall=0 and hold when stall=1.
REQ-013 misalign SHALL pulse for one cycle, registered with the redirect, when target[1]==1; the redirect still occurs.
REQ-014 illegal_br SHALL be registered, pulse for one cycle, and be evaluated only in RUN with stall=0.
REQ-015 Latency from resolution to the new pc SHALL be 1 cycle, with flush asserted in the same cycle as the new pc.

Reset
REQ-016 Asserting rst_n low SHALL immediately set pc=0x0000_0000, state=RUN, flush=0, taken=0, misalign=0, illegal_br=0, br_cnt=0 and taken_cnt=0.
REQ-017 Reset asserted mid-FLUSH SHALL abort the flush; the first cycle after deassertion is RUN with pc=0.

Configuration
REQ-018 Macro PC_BRANCH_PERF_EN SHALL control the counters:
- Defined: br_cnt increments per resolution in RUN with stall=0 and (br_valid|jump); taken_cnt increments per redirect. Both saturate at 0xFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Structure
REQ-019 A shared package pc_branch_pkg SHALL hold:
- the FSM state enum
- funct3 constants F3_BEQ..F3_BGEU
- RESET_PC=32'h0
- FLUSH_CYCLES=2
REQ-020 The decision logic SHALL be one sub-module, branch_decide, that maps funct3, BrEQ, BrLT and jump to taken and illegal; the PC register and FSM stay at top level.

Verification
REQ-021 Reset then 3 cycles idle -> pc sequence 0x0, 0x4, 0x8, 0xC; flush=0.
REQ-022 pc=0x10, br_valid, funct3=000, BrEQ=1, target=0x40 -> next pc=0x40, taken=1, flush=1 for 2 cycles, then pc=0x44 with flush=0.
REQ-023 funct3=101, BrLT=1, target=0x80 -> not taken, pc+4; funct3=110, BrLT=1, BrUn=1 -> redirect.
REQ-024 stall=1 with jump, target=0x200 -> pc holds and no flush; stall drops -> pc=0x200.
REQ-025 Cover the following:
- pc=0xFFFF_FFFC idle -> pc=0x0
- funct3=011 -> illegal_br pulse and pc+4
- target=0x102 -> pc=0x102 and misalign pulse
REQ-026 With PC_BRANCH_PERF_EN defined, 5 branches of which 2 are taken -> br_cnt=5, taken_cnt=2; rst_n low mid-FLUSH -> all counters and flush cleared at once.

Source files
------------

// File: rtl/pc_branch_pkg.sv
// Shared types and constants for the fetch PC / branch resolution unit.
// The optional macro PC_BRANCH_PERF_EN enables the performance counters.
package pc_branch_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Counter preload so that FLUSH lasts FLUSH_CYCLES cycles (counts down to zero).
  localparam logic FLUSH_CNT_INIT = 1'(FLUSH_CYCLES - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_branch_if.sv
// Execute-stage branch inputs and fetch-side outputs of pc_branch_unit.
// Counter outputs only carry live values when PC_BRANCH_PERF_EN is defined.
interface pc_branch_if;
  logic        stall;
  logic        br_valid;
  logic        jump;
  logic [2:0]  funct3;
  logic        BrEQ;
  logic        BrLT;
  logic [31:0] target;
  logic        BrUn;
  logic [31:0] pc;
  logic        flush;
  logic        taken;
  logic        misalign;
  logic        illegal_br;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;

  modport master (
    output stall, br_valid, jump, funct3, BrEQ, BrLT, target,
    input  BrUn, pc, flush, taken, misalign, illegal_br, br_cnt, taken_cnt
  );

  modport slave (
    input  stall, br_valid, jump, funct3, BrEQ, BrLT, target,
    output BrUn, pc, flush, taken, misalign, illegal_br, br_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_branch_unit_decide.sv
// branch_decide: combinational taken/illegal decision from funct3 and comparator flags.
// A jump always wins and never reports an illegal branch encoding.
module branch_decide
  import pc_branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_valid,
  input  logic       jump,
  input  logic       BrEQ,
  input  logic       BrLT,
  output logic       taken,
  output logic       illegal
);

  logic cond_s;
  logic bad_f3_s;

  // Branch condition per funct3 encoding.
  always_comb begin
    cond_s   = 1'b0;
    bad_f3_s = 1'b0;
    case (funct3)
      F3_BEQ:           cond_s = BrEQ;
      F3_BNE:           cond_s = ~BrEQ;
      F3_BLT, F3_BLTU:  cond_s = BrLT;
      F3_BGE, F3_BGEU:  cond_s = ~BrLT;
      default: begin
        cond_s   = 1'b0;
        bad_f3_s = 1'b1;
      end
    endcase
  end

  // Qualify the condition with what is actually present in execute.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (jump) begin
      taken   = 1'b1;
      illegal = 1'b0;
    end else if (br_valid) begin
      taken   = cond_s;
      illegal = bad_f3_s;
    end else begin
      taken   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with branch redirect and two-cycle flush FSM.
// Define PC_BRANCH_PERF_EN to build the saturating br_cnt/taken_cnt counters.
module pc_branch_unit
  import pc_branch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  pc_branch_if.slave   bus
);

  state_e      state_r, state_nxt_s;
  logic        cnt_r, cnt_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic        taken_r, taken_nxt_s;
  logic        flush_r;
  logic        misalign_r, misalign_nxt_s;
  logic        illegal_r, illegal_nxt_s;
  logic        dec_taken_s;
  logic        dec_illegal_s;

  branch_decide u_decide (
    .funct3   (bus.funct3),
    .br_valid (bus.br_valid),
    .jump     (bus.jump),
    .BrEQ     (bus.BrEQ),
    .BrLT     (bus.BrLT),
    .taken    (dec_taken_s),
    .illegal  (dec_illegal_s)
  );

  // Next-state, next-PC and pulse generation.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    pc_nxt_s       = pc_r;
    taken_nxt_s    = taken_r;
    misalign_nxt_s = 1'b0;
    illegal_nxt_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!bus.stall) begin
          illegal_nxt_s = dec_illegal_s;
          if (dec_taken_s) begin
            pc_nxt_s       = {bus.target[31:1], 1'b0};
            taken_nxt_s    = 1'b1;
            misalign_nxt_s = bus.target[1];
            state_nxt_s    = ST_FLUSH;
            cnt_nxt_s      = FLUSH_CNT_INIT;
          end else begin
            pc_nxt_s    = pc_r + PC_STEP;
            taken_nxt_s = 1'b0;
          end
        end else begin
          pc_nxt_s    = pc_r;
          taken_nxt_s = taken_r;
        end
      end
      ST_FLUSH: begin
        // The flush length is fixed in cycles, so the counter ignores stall.
        cnt_nxt_s = cnt_r - 1'b1;
        if (cnt_r == 1'b0) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
        if (!bus.stall) begin
          pc_nxt_s = pc_r + PC_STEP;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      cnt_r      <= 1'b0;
      pc_r       <= RESET_PC;
      taken_r    <= 1'b0;
      flush_r    <= 1'b0;
      misalign_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      pc_r       <= pc_nxt_s;
      taken_r    <= taken_nxt_s;
      flush_r    <= (state_nxt_s == ST_FLUSH);
      misalign_r <= misalign_nxt_s;
      illegal_r  <= illegal_nxt_s;
    end
  end

`ifdef PC_BRANCH_PERF_EN
  logic [31:0] br_cnt_r;
  logic [31:0] taken_cnt_r;
  logic        resolve_s;
  logic        redirect_s;

  assign resolve_s  = (state_r == ST_RUN) & ~bus.stall & (bus.br_valid | bus.jump);
  assign redirect_s = (state_r == ST_RUN) & ~bus.stall & dec_taken_s;

  // Saturating resolution and redirect counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_r    <= 32'd0;
      taken_cnt_r <= 32'd0;
    end else begin
      if (resolve_s) begin
        br_cnt_r <= sat_inc(br_cnt_r);
      end else begin
        br_cnt_r <= br_cnt_r;
      end
      if (redirect_s) begin
        taken_cnt_r <= sat_inc(taken_cnt_r);
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
    end
  end

  assign bus.br_cnt    = br_cnt_r;
  assign bus.taken_cnt = taken_cnt_r;
`else
  assign bus.br_cnt    = 32'd0;
  assign bus.taken_cnt = 32'd0;
`endif

  assign bus.BrUn       = bus.funct3[2] & bus.funct3[1];
  assign bus.pc         = pc_r;
  assign bus.flush      = flush_r;
  assign bus.taken      = taken_r;
  assign bus.misalign   = misalign_r;
  assign bus.illegal_br = illegal_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed, table-driven bench for pc_branch_unit plus a mid-flush reset sequence.
module tb_pc_branch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  pc_branch_if bus_if ();

  pc_branch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        jmp;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        fl;
    logic        tk;
    logic        mis;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic stall, logic bv, logic jmp, logic [2:0] f3,
                              logic eq, logic lt, logic [31:0] tgt,
                              logic [31:0] pc, logic fl, logic tk, logic mis, logic ill);
    vec_t v;
    v.stall = stall; v.bv = bv; v.jmp = jmp; v.f3 = f3; v.eq = eq; v.lt = lt; v.tgt = tgt;
    v.pc = pc; v.fl = fl; v.tk = tk; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.stall    = v.stall;
    bus_if.br_valid = v.bv;
    bus_if.jump     = v.jmp;
    bus_if.funct3   = v.f3;
    bus_if.BrEQ     = v.eq;
    bus_if.BrLT     = v.lt;
    bus_if.target   = v.tgt;
  endtask

  task automatic idle_inputs();
    drive(mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  logic [7:0]  exp_brun;
  logic [31:0] exp_br_cnt;
  logic [31:0] exp_taken_cnt;

  initial begin
    checks = 0;
    passes = 0;
    exp_brun = 8'b1100_0000;
`ifdef PC_BRANCH_PERF_EN
    exp_br_cnt    = 32'd11;
    exp_taken_cnt = 32'd7;
`else
    exp_br_cnt    = 32'd0;
    exp_taken_cnt = 32'd0;
`endif

    //          stall bv  jmp f3      eq    lt    target        pc            fl    tk    mis   ill
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0004,1'b0,1'b0,1'b0,1'b0)); // 1 idle
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0008,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_000C,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0010,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b000,1'b1,1'b0,32'h40,       32'h0000_0040,1'b1,1'b1,1'b0,1'b0)); // 5 BEQ taken
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b000,1'b1,1'b0,32'h300,      32'h0000_0044,1'b1,1'b1,1'b0,1'b0)); // ignored in flush
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0048,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b101,1'b0,1'b1,32'h80,       32'h0000_004C,1'b0,1'b0,1'b0,1'b0)); // 8 BGE not taken
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b110,1'b0,1'b1,32'h80,       32'h0000_0080,1'b1,1'b1,1'b0,1'b0)); // 9 BLTU taken
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0084,1'b1,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0088,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,3'b000,1'b0,1'b0,32'h200,      32'h0000_0088,1'b0,1'b1,1'b0,1'b0)); // 12 stalled jump
    vecs.push_back(mk(1'b1,1'b0,1'b1,3'b000,1'b0,1'b0,32'h200,      32'h0000_0088,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'h200,      32'h0000_0200,1'b1,1'b1,1'b0,1'b0)); // 14 jump
    vecs.push_back(mk(1'b1,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0200,1'b1,1'b1,1'b0,1'b0)); // stall in flush
    vecs.push_back(mk(1'b1,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0200,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b011,1'b0,1'b0,32'h0,        32'h0000_0204,1'b0,1'b0,1'b0,1'b1)); // 17 illegal
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0208,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b001,1'b0,1'b0,32'h103,      32'h0000_0102,1'b1,1'b1,1'b1,1'b0)); // 19 misaligned
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0106,1'b1,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_010A,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,3'b010,1'b0,1'b0,32'h300,      32'h0000_0300,1'b1,1'b1,1'b0,1'b0)); // 22 jump wins
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0304,1'b1,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0308,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b111,1'b0,1'b0,32'h400,      32'h0000_0400,1'b1,1'b1,1'b0,1'b0)); // 25 BGEU taken
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0404,1'b1,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0408,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b100,1'b0,1'b0,32'h500,      32'h0000_040C,1'b0,1'b0,1'b0,1'b0)); // 28 BLT not taken
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,32'h500,      32'h0000_0410,1'b0,1'b0,1'b0,1'b0)); // 29 BEQ not taken
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'hFFFF_FFF4,32'hFFFF_FFF4,1'b1,1'b1,1'b0,1'b0)); // 30
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'hFFFF_FFF8,1'b1,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'hFFFF_FFFC,1'b0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,32'h0,        32'h0000_0000,1'b0,1'b0,1'b0,1'b0)); // wrap

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc",         bus_if.pc,         32'h0);
    chk("rst.flush",      {31'd0, bus_if.flush},      32'd0);
    chk("rst.taken",      {31'd0, bus_if.taken},      32'd0);
    chk("rst.misalign",   {31'd0, bus_if.misalign},   32'd0);
    chk("rst.illegal_br", {31'd0, bus_if.illegal_br}, 32'd0);
    chk("rst.br_cnt",     bus_if.br_cnt,     32'd0);
    chk("rst.taken_cnt",  bus_if.taken_cnt,  32'd0);

    for (int f = 0; f < 8; f++) begin
      bus_if.funct3 = 3'(f);
      #1;
      chk($sformatf("brun.f3_%0d", f), {31'd0, bus_if.BrUn}, {31'd0, exp_brun[f]});
    end
    bus_if.funct3 = 3'b000;

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.pc", i + 1),         bus_if.pc,                  vecs[i].pc);
      chk($sformatf("v%0d.flush", i + 1),      {31'd0, bus_if.flush},      {31'd0, vecs[i].fl});
      chk($sformatf("v%0d.taken", i + 1),      {31'd0, bus_if.taken},      {31'd0, vecs[i].tk});
      chk($sformatf("v%0d.misalign", i + 1),   {31'd0, bus_if.misalign},   {31'd0, vecs[i].mis});
      chk($sformatf("v%0d.illegal_br", i + 1), {31'd0, bus_if.illegal_br}, {31'd0, vecs[i].ill});
      @(negedge clk);
    end

    chk("cnt.br_cnt",    bus_if.br_cnt,    exp_br_cnt);
    chk("cnt.taken_cnt", bus_if.taken_cnt, exp_taken_cnt);

    // Reset in the middle of a flush must clear everything immediately.
    drive(mk(1'b0,1'b0,1'b1,3'b000,1'b0,1'b0,32'h500,32'h0,1'b0,1'b0,1'b0,1'b0));
    @(posedge clk);
    #1;
    chk("mid.pc_redirect", bus_if.pc,             32'h500);
    chk("mid.flush_on",    {31'd0, bus_if.flush}, 32'd1);
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.rst_pc",        bus_if.pc,                32'h0);
    chk("mid.rst_flush",     {31'd0, bus_if.flush},    32'd0);
    chk("mid.rst_taken",     {31'd0, bus_if.taken},    32'd0);
    chk("mid.rst_br_cnt",    bus_if.br_cnt,            32'd0);
    chk("mid.rst_taken_cnt", bus_if.taken_cnt,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post.pc",    bus_if.pc,             32'h0);
    chk("post.flush", {31'd0, bus_if.flush}, 32'd0);
    @(posedge clk);
    #1;
    chk("post.pc_run",    bus_if.pc,             32'h4);
    chk("post.flush_run", {31'd0, bus_if.flush}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
